vector_main_memory: RTL and testbench

//  Main data memory of 12-bit words with two access widths on port A:
//   - scalar: one word;
//   - vector: 6 consecutive words packed into 72 bits.

---
 rtl/mem_pkg.sv | 31 +++
 rtl/vector_main_memory_if.sv | 23 ++
 rtl/mem_bank.sv | 40 ++++
 rtl/vector_main_memory.sv | 99 +++++++++
 tb/tb_vector_main_memory.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared parameters, types and divide-by-6 helpers for the banked vector memory.
package mem_pkg;

    localparam int unsigned ADDR_W = 19;
    localparam int unsigned WORD_W = 12;
    localparam int unsigned LANES  = 6;
    localparam int unsigned VEC_W  = LANES * WORD_W;
    localparam int unsigned DEPTH  = 2 ** ADDR_W;
    localparam int unsigned ROWS   = (DEPTH + LANES - 1) / LANES;
    // One extra code so the row just past the end can be formed without overflow
    localparam int unsigned ROW_W  = $clog2(ROWS + 1);
    localparam int unsigned BANK_W = $clog2(LANES);

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [VEC_W-1:0]  vec_t;
    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [ADDR_W:0]   addr_ext_t;
    typedef logic [ROW_W-1:0]  row_t;
    typedef logic [BANK_W-1:0] bank_t;

    // Row index of a word address within its bank
    function automatic row_t div6(input addr_t a);
        return row_t'(a / addr_t'(LANES));
    endfunction

    // Bank holding a word address
    function automatic bank_t mod6(input addr_t a);
        return bank_t'(a % addr_t'(LANES));
    endfunction

endpackage

// File: rtl/vector_main_memory_if.sv
// Port A (scalar/vector load-store) and port B (scalar read) signal bundle.
interface vector_main_memory_if;
    import mem_pkg::*;

    logic  modeSel;
    addr_t address_a;
    addr_t address_b;
    vec_t  data_a;
    logic  wren;
    vec_t  q_a;
    word_t q_b;

    modport master (
        output modeSel, address_a, address_b, data_a, wren,
        input  q_a, q_b
    );

    modport slave (
        input  modeSel, address_a, address_b, data_a, wren,
        output q_a, q_b
    );

endinterface

// File: rtl/mem_bank.sv
// One interleaved bank: read/write port A plus read-only port B, registered outputs.
module mem_bank
    import mem_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  we,
    input  row_t  addr_a,
    input  word_t wdata,
    input  row_t  addr_b,
    output word_t q_a,
    output word_t q_b
);

    word_t mem [ROWS];
    logic  in_a;
    logic  in_b;

    assign in_a = (addr_a < row_t'(ROWS));
    assign in_b = (addr_b < row_t'(ROWS));

    // Port A write; a row past the last one does not exist and is dropped
    always_ff @(posedge clk) begin
        if (we && in_a) begin
            mem[addr_a] <= wdata;
        end
    end

    // Registered reads; sampling before the write lands yields old data on a collision
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_a <= '0;
            q_b <= '0;
        end else begin
            q_a <= in_a ? mem[addr_a] : '0;
            q_b <= in_b ? mem[addr_b] : '0;
        end
    end

endmodule

// File: rtl/vector_main_memory.sv
// 12-bit word memory with scalar/vector port A and scalar read port B,
// stored as six address-interleaved banks so any 6-word window hits each bank once.
module vector_main_memory
    import mem_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    vector_main_memory_if.slave  bus
);

    bank_t            base_a;
    row_t             row_a0;
    row_t             row_b;
    word_t            lane_in    [LANES];
    bank_t            lane_of    [LANES];
    row_t             bank_row   [LANES];
    word_t            bank_wdata [LANES];
    logic [LANES-1:0] bank_act;
    logic [LANES-1:0] bank_we;
    word_t            rd_a       [LANES];
    word_t            rd_b       [LANES];

    bank_t            sel_a;
    bank_t            sel_b;
    logic [LANES-1:0] mask_a;
    logic [BANK_W:0]  src_sum    [LANES];
    bank_t            src_bank   [LANES];
    vec_t             q_a_c;
    word_t            q_b_c;

    // Map each bank to the lane it serves, its row and whether it takes part
    always_comb begin
        base_a = mod6(bus.address_a);
        row_a0 = div6(bus.address_a);
        row_b  = div6(bus.address_b);
        for (int k = 0; k < LANES; k++) begin
            lane_in[k] = bus.data_a[k*WORD_W +: WORD_W];
        end
        for (int j = 0; j < LANES; j++) begin
            if (bank_t'(j) >= base_a) begin
                lane_of[j]  = bank_t'(j) - base_a;
                bank_row[j] = row_a0;
            end else begin
                lane_of[j]  = bank_t'(j) + bank_t'(LANES) - base_a;
                bank_row[j] = row_a0 + row_t'(1);
            end
            // Vector lanes past the top word are disabled; scalar uses lane 0 only
            bank_act[j]   = bus.modeSel
                          ? ((addr_ext_t'(bus.address_a) + addr_ext_t'(lane_of[j])) < addr_ext_t'(DEPTH))
                          : (lane_of[j] == '0);
            bank_we[j]    = bus.wren && bank_act[j];
            bank_wdata[j] = lane_in[lane_of[j]];
        end
    end

    for (genvar j = 0; j < LANES; j++) begin : g_bank
        mem_bank u_bank (
            .clk    (clk),
            .rst_n  (rst_n),
            .we     (bank_we[j]),
            .addr_a (bank_row[j]),
            .wdata  (bank_wdata[j]),
            .addr_b (row_b),
            .q_a    (rd_a[j]),
            .q_b    (rd_b[j])
        );
    end

    // Capture rotation, lane mask and port B bank alongside the bank reads
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_a  <= '0;
            sel_b  <= '0;
            mask_a <= '0;
        end else begin
            sel_a  <= base_a;
            sel_b  <= mod6(bus.address_b);
            mask_a <= bank_act;
        end
    end

    // Undo the bank rotation and zero disabled lanes
    always_comb begin
        q_a_c = '0;
        for (int k = 0; k < LANES; k++) begin
            src_sum[k] = {1'b0, sel_a} + (BANK_W+1)'(k);
            if (src_sum[k] >= (BANK_W+1)'(LANES)) begin
                src_sum[k] = src_sum[k] - (BANK_W+1)'(LANES);
            end
            src_bank[k] = bank_t'(src_sum[k]);
            q_a_c[k*WORD_W +: WORD_W] = mask_a[src_bank[k]] ? rd_a[src_bank[k]] : '0;
        end
        q_b_c = rd_b[sel_b];
    end

    assign bus.q_a = q_a_c;
    assign bus.q_b = q_b_c;

endmodule

// File: tb/tb_vector_main_memory.sv
// Self-checking bench: stimulus table plus corner sequences and a random phase,
// expectations queued at drive time and compared after the read edge.
module tb_vector_main_memory;
    import mem_pkg::*;

    localparam int TOPW = 2 ** ADDR_W;

    typedef struct {
        string name;
        logic  mode;
        addr_t aa;
        addr_t ab;
        vec_t  da;
        logic  we;
        vec_t  eqa;
        word_t eqb;
    } rec_t;

    typedef struct {
        string name;
        vec_t  qa;
        word_t qb;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_pass = 0;
    int   n_total = 0;
    rec_t tbl[$];
    exp_t sb[$];
    word_t model [int];

    always #5 clk = ~clk;

    vector_main_memory_if bus ();

    vector_main_memory dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic void chk(input string name, input vec_t act, input vec_t exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else n_pass++;
    endfunction

    function automatic vec_t pack6(input int l5, input int l4, input int l3,
                                   input int l2, input int l1, input int l0);
        return {word_t'(l5), word_t'(l4), word_t'(l3), word_t'(l2), word_t'(l1), word_t'(l0)};
    endfunction

    function automatic vec_t sc(input int w);
        return vec_t'(word_t'(w));
    endfunction

    function automatic rec_t mk(input string name, input logic mode, input int aa, input int ab,
                                input vec_t da, input logic we, input vec_t eqa, input int eqb);
        rec_t r;
        r.name = name; r.mode = mode; r.aa = addr_t'(aa); r.ab = addr_t'(ab);
        r.da = da; r.we = we; r.eqa = eqa; r.eqb = word_t'(eqb);
        return r;
    endfunction

    function automatic word_t mrd(input int a);
        if (a >= TOPW) return '0;
        if (model.exists(a)) return model[a];
        return '0;
    endfunction

    function automatic vec_t mexp(input logic mode, input int a);
        vec_t r = '0;
        if (!mode) r[WORD_W-1:0] = mrd(a);
        else for (int k = 0; k < LANES; k++) r[k*WORD_W +: WORD_W] = mrd(a + k);
        return r;
    endfunction

    function automatic void mwr(input logic mode, input int a, input vec_t d);
        if (!mode) model[a] = d[WORD_W-1:0];
        else for (int k = 0; k < LANES; k++)
            if (a + k < TOPW) model[a + k] = d[k*WORD_W +: WORD_W];
    endfunction

    // Drive one access, queue its expectation, compare after the edge
    task automatic step(input rec_t r);
        exp_t e;
        bus.modeSel   = r.mode;
        bus.address_a = r.aa;
        bus.address_b = r.ab;
        bus.data_a    = r.da;
        bus.wren      = r.we;
        e.name = r.name; e.qa = r.eqa; e.qb = r.eqb;
        sb.push_back(e);
        @(posedge clk);
        if (r.we) mwr(r.mode, int'(r.aa), r.da);
        #1;
        e = sb.pop_front();
        chk({e.name, ".q_a"}, bus.q_a, e.qa);
        chk({e.name, ".q_b"}, vec_t'(bus.q_b), vec_t'(e.qb));
        bus.wren = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t v, v_old, w, mixed;
        int   vals[6];
        rec_t r;

        bus.modeSel = 1'b0; bus.address_a = '0; bus.address_b = '0;
        bus.data_a = '0; bus.wren = 1'b0;

        v     = pack6(32, 28, 46, 93, 10, 59);
        v_old = pack6(0, 32, 28, 46, 93, 10);
        w     = pack6(6, 5, 4, 3, 2, 1);
        mixed = pack6(32, 28, 46, 20, 10, 59);
        vals  = '{59, 10, 93, 46, 28, 32};

        tbl.push_back(mk("init_rd",   0, 500, 500, '0, 0, '0, 0));
        tbl.push_back(mk("wr99",      0, 500, 500, sc(99), 1, '0, 0));
        tbl.push_back(mk("rd500",     0, 500, 500, '0, 0, sc(99), 99));
        tbl.push_back(mk("wr27",      0, 700, 500, sc(27), 1, '0, 99));
        tbl.push_back(mk("rd700",     0, 700, 500, '0, 0, sc(27), 99));
        for (int n = 0; n < 6; n++) begin
            tbl.push_back(mk($sformatf("vwr%0d", 870 + n), 1, 870 + n, 500, v, 1,
                             (n == 0) ? '0 : v_old, 99));
            tbl.push_back(mk($sformatf("vrd%0d", 870 + n), 1, 870 + n, 500, '0, 0, v, 99));
        end
        for (int k = 0; k < 6; k++)
            tbl.push_back(mk($sformatf("srd%0d", 875 + k), 0, 875 + k, 875 + k, '0, 0,
                             sc(vals[k]), vals[k]));
        tbl.push_back(mk("wr20",      0, 877, 877, sc(20), 1, sc(93), 93));
        tbl.push_back(mk("mixed_vrd", 1, 875, 877, '0, 0, mixed, 20));
        tbl.push_back(mk("top_vwr",   1, TOPW - 3, TOPW - 3, w, 1, '0, 0));
        tbl.push_back(mk("top_vrd",   1, TOPW - 3, TOPW - 1, '0, 0, pack6(0, 0, 0, 3, 2, 1), 3));
        tbl.push_back(mk("top_srd",   0, TOPW - 1, TOPW - 2, '0, 0, sc(3), 2));
        tbl.push_back(mk("nowrap",    1, 0, 0, '0, 0, '0, 0));
        tbl.push_back(mk("last_vwr",  1, TOPW - 1, TOPW - 1, pack6(9, 9, 9, 9, 9, 7), 1,
                         pack6(0, 0, 0, 0, 0, 3), 3));
        tbl.push_back(mk("last_vrd",  1, TOPW - 1, 0, '0, 0, pack6(0, 0, 0, 0, 0, 7), 0));
        tbl.push_back(mk("nowrap2",   1, 0, TOPW - 1, '0, 0, '0, 7));
        tbl.push_back(mk("rdw_wr",    0, 500, 500, sc(111), 1, sc(99), 99));
        tbl.push_back(mk("rdw_rd",    0, 500, 500, '0, 0, sc(111), 111));

        // Reset holds outputs at zero
        repeat (2) @(posedge clk);
        #1;
        chk("reset.q_a", bus.q_a, '0);
        chk("reset.q_b", vec_t'(bus.q_b), '0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

        // Mode change mid-cycle must not disturb q_a before the next edge
        step(mk("hold_vrd", 1, 875, 500, '0, 0, mixed, 111));
        bus.modeSel = 1'b0;
        bus.address_a = addr_t'(500);
        #2;
        chk("hold.q_a", bus.q_a, mixed);
        step(mk("hold_srd", 0, 500, 500, '0, 0, sc(111), 111));

        // Asynchronous reset mid-run clears outputs at once, memory survives
        step(mk("pre_rst", 1, 875, 877, '0, 0, mixed, 20));
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst.q_a", bus.q_a, '0);
        chk("midrst.q_b", vec_t'(bus.q_b), '0);
        @(posedge clk);
        #1;
        chk("midrst_edge.q_a", bus.q_a, '0);
        @(negedge clk);
        rst_n = 1'b1;
        step(mk("post_rst_s", 0, 500, 500, '0, 0, sc(111), 111));
        step(mk("post_rst_v", 1, 875, 877, '0, 0, mixed, 20));

        // Random mixed traffic in a low window and at the top boundary
        for (int i = 0; i < 60; i++) begin
            int   base, aa, ab;
            logic mode;
            base = ($urandom_range(0, 1) == 0) ? 1000 : TOPW - 8;
            aa   = base + int'($urandom_range(0, 7));
            ab   = base + int'($urandom_range(0, 7));
            mode = 1'($urandom_range(0, 1));
            r = mk($sformatf("rnd%0d", i), mode, aa, ab,
                   vec_t'({$urandom, $urandom, $urandom}), 1'($urandom_range(0, 1)),
                   mexp(mode, aa), int'(mrd(ab)));
            step(r);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
